// File: rtl/dmem_responder.sv
// Data-memory responder: one load/store at a time over valid/ready, fixed LATENCY, word array of DEPTH.
// Optional DMEM_INIT_EN: reset also loads word i = 10*i for i=0..5 and clears the rest.
//
// state | meaning
// IDLE  | ready for a request; latches it on req_valid_i
// BUSY  | latency countdown, request pending
// RESP  | response held on rsp_* until rsp_ready_i
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic          accept, go_resp, mem_we;
  logic          acc_we, acc_err;
  logic [31:0]   acc_addr, acc_wdata;
  logic [AW-1:0] acc_idx;
  logic [31:0]   mem_q [DEPTH];

  assign accept = (state_q == S_IDLE) && req_valid_i;

  // With LATENCY=1 the access happens on the accept edge, so it must see the live request.
  assign acc_we    = (state_q == S_IDLE) ? req_we_i    : we_q;
  assign acc_addr  = (state_q == S_IDLE) ? req_addr_i  : addr_q;
  assign acc_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
  assign acc_idx   = acc_addr[AW+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);
  assign mem_we    = go_resp && acc_we && !acc_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    go_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            go_resp = 1'b1;
          end else begin
            cnt_d   = 4'(LATENCY - 1);
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) go_resp = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (go_resp) begin
      state_d = S_RESP;
      err_d   = acc_err;
      rdata_d = (acc_err || acc_we) ? 32'h0 : mem_q[acc_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q    <= req_we_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
    end
  end

`ifdef DMEM_INIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= (i < 6) ? 32'(10 * i) : 32'h0;
    end else if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[acc_idx] <= acc_wdata;
  end
`endif

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (LATENCY 2, 4, 1), vector table plus corner sequences.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_we    [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_ready [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_we_i(req_we[0]), .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]), .rsp_rdata_o(rsp_rdata[0]),
    .rsp_err_o(rsp_err[0]));

  dmem_responder #(.DEPTH(256), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_we_i(req_we[1]), .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]), .rsp_rdata_o(rsp_rdata[1]),
    .rsp_err_o(rsp_err[1]));

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_we_i(req_we[2]), .req_addr_i(req_addr[2]), .req_wdata_i(req_wdata[2]),
    .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready[2]), .rsp_rdata_o(rsp_rdata[2]),
    .rsp_err_o(rsp_err[2]));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [11];

  function automatic int lat(input int d);
    return (d == 0) ? 2 : (d == 1) ? 4 : 1;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Full transaction with rsp_ready held high; called #1 after a rising edge.
  task automatic txn(input int d, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rd, input logic exp_err, input string nm);
    int n;
    req_we[d] = we; req_addr[d] = addr; req_wdata[d] = wdata;
    req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_addr[d] = $urandom; req_wdata[d] = $urandom; req_we[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 20) begin @(posedge clk); #1; n++; end
    check({nm, " latency"}, 32'(n), 32'(lat(d) - 1));
    check({nm, " rdata"}, rsp_rdata[d], exp_rd);
    check({nm, " err"}, 32'(rsp_err[d]), 32'(exp_err));
    @(posedge clk); #1;
    check({nm, " consumed"}, {30'h0, rsp_valid[d], req_ready[d]}, 32'h1);
  endtask

  initial begin
    int n;
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0;
      req_wdata[d] = '0; rsp_ready[d] = 1'b0;
    end
    vecs[0]  = '{1'b0, 32'h0000000C, 32'h0,        32'd30,        1'b0};
    vecs[1]  = '{1'b1, 32'h00000010, 32'hDEADBEEF, 32'h0,         1'b0};
    vecs[2]  = '{1'b0, 32'h00000010, 32'h0,        32'hDEADBEEF,  1'b0};
    vecs[3]  = '{1'b0, 32'h00000006, 32'h0,        32'h0,         1'b1};
    vecs[4]  = '{1'b1, 32'h00000400, 32'h12345678, 32'h0,         1'b1};
    vecs[5]  = '{1'b0, 32'h00000000, 32'h0,        32'h0,         1'b0};
    vecs[6]  = '{1'b1, 32'h000003FC, 32'h0000A5A5, 32'h0,         1'b0};
    vecs[7]  = '{1'b0, 32'h000003FC, 32'h0,        32'h0000A5A5,  1'b0};
    vecs[8]  = '{1'b0, 32'h80000000, 32'h0,        32'h0,         1'b1};
    vecs[9]  = '{1'b1, 32'h00000005, 32'h000000FF, 32'h0,         1'b1};
    vecs[10] = '{1'b0, 32'h00000004, 32'h0,        32'd10,        1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset req_ready", 32'(req_ready[0]), 32'h1);
    check("reset rsp_valid", 32'(rsp_valid[0]), 32'h0);
    check("reset rsp_rdata", rsp_rdata[0], 32'h0);
    check("reset rsp_err", 32'(rsp_err[0]), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef DMEM_INIT_EN
    txn(0, 1'b0, 32'h14, 32'h0, 32'd50, 1'b0, "init word5");
`endif
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 6; i++)
        txn(d, 1'b1, 32'(4 * i), 32'(10 * i), 32'h0, 1'b0, "prewrite");

    for (int i = 0; i < 11; i++)
      txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err,
          $sformatf("vec%0d", i));

    // Backpressure: hold the load-0x4 response for 5 cycles while a second request waits.
    req_we[0] = 1'b0; req_addr[0] = 32'h4; req_valid[0] = 1'b1; rsp_ready[0] = 1'b0;
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_wdata[0] = 32'h99;
    n = 0;
    while (!rsp_valid[0] && n < 20) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp valid c%0d", c), 32'(rsp_valid[0]), 32'h1);
      check($sformatf("bp rdata c%0d", c), rsp_rdata[0], 32'd10);
      check($sformatf("bp req_ready c%0d", c), 32'(req_ready[0]), 32'h0);
      @(posedge clk); #1;
    end
    req_valid[0] = 1'b0; rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    check("bp consumed", 32'(rsp_valid[0]), 32'h0);
    txn(0, 1'b0, 32'h4, 32'h0, 32'd10, 1'b0, "bp ignored store");

    // LATENCY=1 back-to-back loads with req_valid held high.
    req_we[2] = 1'b0; req_addr[2] = 32'h4; req_valid[2] = 1'b1; rsp_ready[2] = 1'b1;
    @(posedge clk); #1;
    check("b2b rsp1 valid", 32'(rsp_valid[2]), 32'h1);
    check("b2b rsp1 rdata", rsp_rdata[2], 32'd10);
    check("b2b busy ready", 32'(req_ready[2]), 32'h0);
    req_addr[2] = 32'h8;
    @(posedge clk); #1;
    check("b2b gap valid", 32'(rsp_valid[2]), 32'h0);
    check("b2b gap ready", 32'(req_ready[2]), 32'h1);
    @(posedge clk); #1;
    check("b2b rsp2 valid", 32'(rsp_valid[2]), 32'h1);
    check("b2b rsp2 rdata", rsp_rdata[2], 32'd20);
    req_valid[2] = 1'b0;
    @(posedge clk); #1;
    check("b2b done", 32'(rsp_valid[2]), 32'h0);

    // Reset while a store is in BUSY on the LATENCY=4 instance.
    req_we[1] = 1'b1; req_addr[1] = 32'h8; req_wdata[1] = 32'h55; req_valid[1] = 1'b1;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    check("mid busy ready", 32'(req_ready[1]), 32'h0);
    rst_n = 1'b0;
    #1;
    check("rst req_ready", 32'(req_ready[1]), 32'h1);
    check("rst rsp_valid", 32'(rsp_valid[1]), 32'h0);
    check("rst rsp_rdata", rsp_rdata[1], 32'h0);
    check("rst rsp_err", 32'(rsp_err[1]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1, 1'b0, 32'h8, 32'h0, 32'd20, 1'b0, "after rst load");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
